// File: rtl/mem_pkg.sv
// Package shared by the MMU memory-side responder.
// Contents:
//   state_t        - responder FSM states
//   REQ_READ/WRITE - encoding of req_mode
//   AXI_RESP_OKAY  - AXI response code treated as success
package mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_A,
      ST_RD_D,
      ST_WR_AW,
      ST_WR_B
   } state_t;

   localparam logic       REQ_READ      = 1'b0;
   localparam logic       REQ_WRITE     = 1'b1;
   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/mem_req_axi_responder.sv
// mem_req_axi_responder
// Memory-side responder for the MMU physical request port. Takes one request at
// a time and performs it as a single AXI4-Lite read or write, then pulses
// response_enable with the read data (or zero for writes).
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   request_enable, req_*      1-cycle request pulse with mode/addr/wdata/wstrb
//   response_enable, resp_data 1-cycle completion pulse, held read data
//   bus_error                  with response_enable: slave answered non-OKAY
//   req_overlap                sticky: request arrived while busy (dropped)
//   last_latency               accept-to-response cycle count, saturating
//   axi_*                      AXI4-Lite master, 32-bit address/data
module mem_req_axi_responder
   import mem_pkg::*;
#(
   parameter int unsigned ALIGN_ADDR = 1,
   parameter int unsigned LAT_W      = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             request_enable,
   input  logic             req_mode,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   input  logic [3:0]       req_wstrb,
   output logic             response_enable,
   output logic [31:0]      resp_data,
   output logic             bus_error,
   output logic             req_overlap,
   output logic [LAT_W-1:0] last_latency,
   output logic [31:0]      axi_araddr,
   output logic [2:0]       axi_arprot,
   output logic             axi_arvalid,
   input  logic             axi_arready,
   input  logic [31:0]      axi_rdata,
   input  logic [1:0]       axi_rresp,
   input  logic             axi_rvalid,
   output logic             axi_rready,
   output logic [31:0]      axi_awaddr,
   output logic [2:0]       axi_awprot,
   output logic             axi_awvalid,
   input  logic             axi_awready,
   output logic [31:0]      axi_wdata,
   output logic [3:0]       axi_wstrb,
   output logic             axi_wvalid,
   input  logic             axi_wready,
   input  logic [1:0]       axi_bresp,
   input  logic             axi_bvalid,
   output logic             axi_bready
);

   state_t           state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [3:0]       wstrb_q, wstrb_d;
   logic             arvalid_q, arvalid_d;
   logic             rready_q, rready_d;
   logic             awvalid_q, awvalid_d;
   logic             wvalid_q, wvalid_d;
   logic             bready_q, bready_d;
   logic             resp_en_q, resp_en_d;
   logic [31:0]      resp_data_q, resp_data_d;
   logic             bus_err_q, bus_err_d;
   logic             overlap_q, overlap_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   logic [LAT_W-1:0] last_lat_q, last_lat_d;
   logic [LAT_W-1:0] lat_inc;
   logic             aw_pending;
   logic             w_pending;

   assign lat_inc = (&lat_q) ? lat_q : lat_q + 1'b1;

   // A channel is still pending while its valid is up and not yet accepted;
   // W and AW retire independently and the FSM waits for both.
   assign aw_pending = awvalid_q && !axi_awready;
   assign w_pending  = wvalid_q  && !axi_wready;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      resp_en_d   = 1'b0;
      resp_data_d = resp_data_q;
      bus_err_d   = 1'b0;
      last_lat_d  = last_lat_q;
      lat_d       = (state_q != ST_IDLE) ? lat_inc : lat_q;
      overlap_d   = overlap_q | (request_enable && (state_q != ST_IDLE));

      case (state_q)
         ST_IDLE: begin
            if (request_enable) begin
               addr_d  = (ALIGN_ADDR != 0) ? {req_addr[31:2], 2'b00} : req_addr;
               wdata_d = req_wdata;
               wstrb_d = req_wstrb;
               lat_d   = '0;
               if (req_mode == REQ_READ) begin
                  state_d   = ST_RD_A;
                  arvalid_d = 1'b1;
               end else begin
                  state_d   = ST_WR_AW;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end
            end
         end
         ST_RD_A: begin
            if (arvalid_q && axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = ST_RD_D;
            end
         end
         ST_RD_D: begin
            // State is held through the response cycle so a request landing
            // on that cycle still counts as an overlap.
            if (resp_en_q) begin
               state_d    = ST_IDLE;
               last_lat_d = lat_inc;
            end else if (rready_q && axi_rvalid) begin
               rready_d    = 1'b0;
               resp_data_d = axi_rdata;
               bus_err_d   = (axi_rresp != AXI_RESP_OKAY);
               resp_en_d   = 1'b1;
            end
         end
         ST_WR_AW: begin
            if (awvalid_q && axi_awready) awvalid_d = 1'b0;
            if (wvalid_q && axi_wready)   wvalid_d  = 1'b0;
            if (!aw_pending && !w_pending) begin
               bready_d = 1'b1;
               state_d  = ST_WR_B;
            end
         end
         ST_WR_B: begin
            if (resp_en_q) begin
               state_d    = ST_IDLE;
               last_lat_d = lat_inc;
            end else if (bready_q && axi_bvalid) begin
               bready_d    = 1'b0;
               resp_data_d = '0;
               bus_err_d   = (axi_bresp != AXI_RESP_OKAY);
               resp_en_d   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         resp_en_q   <= 1'b0;
         resp_data_q <= '0;
         bus_err_q   <= 1'b0;
         overlap_q   <= 1'b0;
         lat_q       <= '0;
         last_lat_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         resp_en_q   <= resp_en_d;
         resp_data_q <= resp_data_d;
         bus_err_q   <= bus_err_d;
         overlap_q   <= overlap_d;
         lat_q       <= lat_d;
         last_lat_q  <= last_lat_d;
      end
   end

   assign response_enable = resp_en_q;
   assign resp_data       = resp_data_q;
   assign bus_error       = bus_err_q;
   assign req_overlap     = overlap_q;
   assign last_latency    = last_lat_q;
   assign axi_araddr      = addr_q;
   assign axi_arprot      = 3'b000;
   assign axi_arvalid     = arvalid_q;
   assign axi_rready      = rready_q;
   assign axi_awaddr      = addr_q;
   assign axi_awprot      = 3'b000;
   assign axi_awvalid     = awvalid_q;
   assign axi_wdata       = wdata_q;
   assign axi_wstrb       = wstrb_q;
   assign axi_wvalid      = wvalid_q;
   assign axi_bready      = bready_q;

endmodule
